riscv_pipe_stage: RTL and testbench

Parametrised elastic pipeline-stage register that replaces the hand-written per-stage latch modules (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field between adjacent stages using a valid/ready handshake instead of a bare stall level.
- Optional 2-entry skid buffer registers the upstream ready path.
- Synchronous flush inserts a bubble; a saturating counter records squashed instructions for debug.

---
 rtl/riscv_pipe_pkg.sv | 50 +++++
 rtl/riscv_pipe_stage_flush_cnt.sv | 41 ++++
 rtl/riscv_pipe_stage.sv | 156 +++++++++++++++
 tb/tb_riscv_pipe_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers: per-stage
// bus widths, packed field offsets and the occupancy encoding.
package riscv_pipe_pkg;

   // Per-stage control/data widths
   localparam int IFID_CTRL_W  = 4;
   localparam int IFID_DATA_W  = 64;
   localparam int IDEX_CTRL_W  = 8;
   localparam int IDEX_DATA_W  = 160;
   localparam int EXMEM_CTRL_W = 8;
   localparam int EXMEM_DATA_W = 133;
   localparam int MEMWB_CTRL_W = 4;
   localparam int MEMWB_DATA_W = 69;

   // Control field bit offsets (shared layout, later stages use a prefix)
   localparam int CTRL_REGWR_BIT  = 0;
   localparam int CTRL_MEMWR_BIT  = 1;
   localparam int CTRL_MEMRD_BIT  = 2;
   localparam int CTRL_BROP_LSB   = 3;
   localparam int CTRL_BROP_W     = 3;
   localparam int CTRL_WBSEL_LSB  = 6;
   localparam int CTRL_WBSEL_W    = 2;

   // Data field offsets for the ID/EX and EX/MEM buses
   localparam int DATA_PC_LSB   = 0;
   localparam int DATA_RS1_LSB  = 32;
   localparam int DATA_RS2_LSB  = 64;
   localparam int DATA_IMM_LSB  = 96;
   localparam int DATA_RD_LSB   = 128;
   localparam int DATA_RD_W     = 5;

   // Occupancy encoding (also the skid state machine state)
   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

   // Number of held entries lost by a flush: held entries minus the one
   // that downstream takes in the same cycle.
   function automatic logic [1:0] flush_loss(input logic [1:0] occ, input logic emit);
      logic [1:0] loss;
      case (occ)
         OCC_EMPTY: loss = 2'd0;
         OCC_ONE:   loss = emit ? 2'd0 : 2'd1;
         OCC_TWO:   loss = emit ? 2'd1 : 2'd2;
         default:   loss = 2'd0;
      endcase
      return loss;
   endfunction

endpackage

// File: rtl/riscv_pipe_stage_flush_cnt.sv
// Saturating debug counter of instructions squashed by flush.
module riscv_pipe_flush_cnt
   import riscv_pipe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W:0] SAT_VAL = {1'b0, {CNT_W{1'b1}}};

   logic [CNT_W:0]   sum_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;

   // Add the increment one bit wider and clamp at all-ones so it never wraps
   always_comb begin
      sum_s     = {1'b0, cnt_r} + (CNT_W+1)'(inc);
      cnt_nxt_s = cnt_r;
      if (sum_s > SAT_VAL) begin
         cnt_nxt_s = {CNT_W{1'b1}};
      end else begin
         cnt_nxt_s = sum_s[CNT_W-1:0];
      end
   end

   // Counter register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else begin
         cnt_r <= cnt_nxt_s;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/riscv_pipe_stage.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a flushed-entry counter.
module riscv_pipe_stage
   import riscv_pipe_pkg::*;
#(
   parameter int CTRL_W     = 8,
   parameter int DATA_W     = 160,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  flushed_cnt
);

   logic [1:0]        occ_r;
   logic [1:0]        occ_nxt_s;
   logic              out_valid_r;
   logic              in_ready_r;
   logic              in_ready_s;
   logic              accept_s;
   logic              emit_s;
   logic [1:0]        flush_inc_s;
   logic [CTRL_W-1:0] main_ctrl_r, main_ctrl_nxt_s;
   logic [DATA_W-1:0] main_data_r, main_data_nxt_s;
   logic [CTRL_W-1:0] skid_ctrl_r, skid_ctrl_nxt_s;
   logic [DATA_W-1:0] skid_data_r, skid_data_nxt_s;

   // With the skid buffer in_ready comes straight from a flop; without it
   // the stage can accept whenever its single slot empties this cycle.
   generate
      if (SKID != 0) begin : g_skid_ready
         assign in_ready_s = in_ready_r;
      end else begin : g_comb_ready
         assign in_ready_s = ~out_valid_r | out_ready;
      end
   endgenerate

   assign accept_s = in_valid & in_ready_s;
   assign emit_s   = out_valid_r & out_ready;

   // Next-state and datapath steering; control is zeroed whenever the
   // main slot empties so a bubble never carries RegWr/MemWr.
   always_comb begin
      occ_nxt_s       = occ_r;
      main_ctrl_nxt_s = main_ctrl_r;
      main_data_nxt_s = main_data_r;
      skid_ctrl_nxt_s = skid_ctrl_r;
      skid_data_nxt_s = skid_data_r;
      flush_inc_s     = 2'd0;
      if (flush) begin
         occ_nxt_s       = OCC_EMPTY;
         main_ctrl_nxt_s = {CTRL_W{1'b0}};
         skid_ctrl_nxt_s = {CTRL_W{1'b0}};
         flush_inc_s     = flush_loss(occ_r, emit_s);
         if (CLEAR_DATA != 0) begin
            main_data_nxt_s = {DATA_W{1'b0}};
            skid_data_nxt_s = {DATA_W{1'b0}};
         end else begin
            main_data_nxt_s = main_data_r;
            skid_data_nxt_s = skid_data_r;
         end
      end else begin
         case (occ_r)
            OCC_EMPTY: begin
               if (accept_s) begin
                  occ_nxt_s       = OCC_ONE;
                  main_ctrl_nxt_s = in_ctrl;
                  main_data_nxt_s = in_data;
               end else begin
                  occ_nxt_s = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (accept_s && emit_s) begin
                  occ_nxt_s       = OCC_ONE;
                  main_ctrl_nxt_s = in_ctrl;
                  main_data_nxt_s = in_data;
               end else if (accept_s) begin
                  occ_nxt_s       = OCC_TWO;
                  skid_ctrl_nxt_s = in_ctrl;
                  skid_data_nxt_s = in_data;
               end else if (emit_s) begin
                  occ_nxt_s       = OCC_EMPTY;
                  main_ctrl_nxt_s = {CTRL_W{1'b0}};
               end else begin
                  occ_nxt_s = OCC_ONE;
               end
            end
            OCC_TWO: begin
               if (emit_s) begin
                  occ_nxt_s       = OCC_ONE;
                  main_ctrl_nxt_s = skid_ctrl_r;
                  main_data_nxt_s = skid_data_r;
                  skid_ctrl_nxt_s = {CTRL_W{1'b0}};
               end else begin
                  occ_nxt_s = OCC_TWO;
               end
            end
            default: begin
               occ_nxt_s       = OCC_EMPTY;
               main_ctrl_nxt_s = {CTRL_W{1'b0}};
               skid_ctrl_nxt_s = {CTRL_W{1'b0}};
            end
         endcase
      end
   end

   // State, handshake flags and the main/skid registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_r       <= OCC_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         main_ctrl_r <= {CTRL_W{1'b0}};
         main_data_r <= {DATA_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         skid_data_r <= {DATA_W{1'b0}};
      end else begin
         occ_r       <= occ_nxt_s;
         out_valid_r <= (occ_nxt_s != OCC_EMPTY);
         in_ready_r  <= (occ_nxt_s != OCC_TWO);
         main_ctrl_r <= main_ctrl_nxt_s;
         main_data_r <= main_data_nxt_s;
         skid_ctrl_r <= skid_ctrl_nxt_s;
         skid_data_r <= skid_data_nxt_s;
      end
   end

   riscv_pipe_flush_cnt #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc_s),
      .cnt   (flushed_cnt)
   );

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_ctrl  = main_ctrl_r;
   assign out_data  = main_data_r;
   assign occupancy = occ_r;

endmodule

// File: tb/tb_riscv_pipe_stage.sv
// Directed bench for riscv_pipe_stage: a vector table for the default
// SKID=1 stage plus short sequences for saturation and SKID=0.
module tb_riscv_pipe_stage;

   typedef struct {
      logic        iv;
      logic [7:0]  ictrl;
      logic [15:0] idata;
      logic        ordy;
      logic        fl;
      logic        ov;
      logic [7:0]  octrl;
      logic [15:0] odata;
      logic [1:0]  occ;
      logic        irdy;
      logic [15:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Main DUT: default parameters
   logic         iv, irdy, ordy, fl, ov;
   logic [7:0]   ictrl, octrl;
   logic [159:0] idata, odata;
   logic [1:0]   occ;
   logic [15:0]  cnt;

   // Saturation DUT: CNT_W=2, CLEAR_DATA=1
   logic         s_iv, s_irdy, s_ordy, s_fl, s_ov;
   logic [7:0]   s_ictrl, s_octrl;
   logic [15:0]  s_idata, s_odata;
   logic [1:0]   s_occ;
   logic [1:0]   s_cnt;

   // SKID=0 DUT
   logic         z_iv, z_irdy, z_ordy, z_fl, z_ov;
   logic [7:0]   z_ictrl, z_octrl;
   logic [15:0]  z_idata, z_odata;
   logic [1:0]   z_occ;
   logic [15:0]  z_cnt;

   int checks = 0;
   int failures = 0;
   vec_t tbl [27];

   always #5 clk = ~clk;

   riscv_pipe_stage u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(irdy), .in_ctrl(ictrl),
      .in_data(idata), .out_valid(ov), .out_ready(ordy), .out_ctrl(octrl),
      .out_data(odata), .flush(fl), .occupancy(occ), .flushed_cnt(cnt)
   );

   riscv_pipe_stage #(.CTRL_W(8), .DATA_W(16), .SKID(1), .CLEAR_DATA(1), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_irdy), .in_ctrl(s_ictrl),
      .in_data(s_idata), .out_valid(s_ov), .out_ready(s_ordy), .out_ctrl(s_octrl),
      .out_data(s_odata), .flush(s_fl), .occupancy(s_occ), .flushed_cnt(s_cnt)
   );

   riscv_pipe_stage #(.CTRL_W(8), .DATA_W(16), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u_s0 (
      .clk(clk), .rst_n(rst_n), .in_valid(z_iv), .in_ready(z_irdy), .in_ctrl(z_ictrl),
      .in_data(z_idata), .out_valid(z_ov), .out_ready(z_ordy), .out_ctrl(z_octrl),
      .out_data(z_odata), .flush(z_fl), .occupancy(z_occ), .flushed_cnt(z_cnt)
   );

   function automatic vec_t mk(input logic iv_i, input logic [7:0] ic, input logic [15:0] id,
                               input logic ordy_i, input logic fl_i, input logic ov_i,
                               input logic [7:0] oc, input logic [15:0] od, input logic [1:0] oo,
                               input logic ir, input logic [15:0] cn);
      vec_t v;
      v.iv = iv_i; v.ictrl = ic; v.idata = id; v.ordy = ordy_i; v.fl = fl_i;
      v.ov = ov_i; v.octrl = oc; v.odata = od; v.occ = oo; v.irdy = ir; v.cnt = cn;
      return v;
   endfunction

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   initial begin
      logic ov_m;
      logic [15:0] data_m;
      logic rdy_m;

      iv = 1'b1; ictrl = 8'hFF; idata = 160'h0; ordy = 1'b0; fl = 1'b0;
      s_iv = 1'b0; s_ictrl = 8'h00; s_idata = 16'h0; s_ordy = 1'b0; s_fl = 1'b0;
      z_iv = 1'b0; z_ictrl = 8'h00; z_idata = 16'h0; z_ordy = 1'b0; z_fl = 1'b0;

      // Vector table: streaming, stall/skid, flush corner cases
      for (int k = 1; k <= 10; k++) begin
         tbl[k-1] = mk(1'b1, 8'(8'h10 + k), 16'(k), 1'b1, 1'b0,
                       1'b1, 8'(8'h10 + k), 16'(k), 2'd1, 1'b1, 16'd0);
      end
      tbl[10] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h000A, 2'd0, 1'b1, 16'd0);
      tbl[11] = mk(1'b1, 8'hA1, 16'h00A0, 1'b0, 1'b0, 1'b1, 8'hA1, 16'h00A0, 2'd1, 1'b1, 16'd0);
      tbl[12] = mk(1'b1, 8'hB1, 16'h00B0, 1'b0, 1'b0, 1'b1, 8'hA1, 16'h00A0, 2'd2, 1'b0, 16'd0);
      tbl[13] = mk(1'b1, 8'hC1, 16'h00C0, 1'b0, 1'b0, 1'b1, 8'hA1, 16'h00A0, 2'd2, 1'b0, 16'd0);
      tbl[14] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b1, 8'hB1, 16'h00B0, 2'd1, 1'b1, 16'd0);
      tbl[15] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h00B0, 2'd0, 1'b1, 16'd0);
      tbl[16] = mk(1'b1, 8'hD1, 16'h00D0, 1'b0, 1'b0, 1'b1, 8'hD1, 16'h00D0, 2'd1, 1'b1, 16'd0);
      tbl[17] = mk(1'b1, 8'hE1, 16'h00E0, 1'b0, 1'b0, 1'b1, 8'hD1, 16'h00D0, 2'd2, 1'b0, 16'd0);
      tbl[18] = mk(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 16'h00D0, 2'd0, 1'b1, 16'd2);
      tbl[19] = mk(1'b1, 8'hF1, 16'h00F0, 1'b0, 1'b0, 1'b1, 8'hF1, 16'h00F0, 2'd1, 1'b1, 16'd2);
      tbl[20] = mk(1'b1, 8'h71, 16'h0070, 1'b0, 1'b0, 1'b1, 8'hF1, 16'h00F0, 2'd2, 1'b0, 16'd2);
      tbl[21] = mk(1'b1, 8'h55, 16'h0055, 1'b1, 1'b1, 1'b0, 8'h00, 16'h00F0, 2'd0, 1'b1, 16'd3);
      tbl[22] = mk(1'b1, 8'h81, 16'h0080, 1'b0, 1'b0, 1'b1, 8'h81, 16'h0080, 2'd1, 1'b1, 16'd3);
      tbl[23] = mk(1'b1, 8'h91, 16'h0090, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0080, 2'd0, 1'b1, 16'd3);
      tbl[24] = mk(1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0080, 2'd0, 1'b1, 16'd3);
      tbl[25] = mk(1'b1, 8'hC7, 16'h00C6, 1'b0, 1'b0, 1'b1, 8'hC7, 16'h00C6, 2'd1, 1'b1, 16'd3);
      tbl[26] = mk(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 16'h00C6, 2'd0, 1'b1, 16'd4);

      // Reset with a valid beat presented
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 160'(ov), 160'(1'b0));
      check("rst_out_ctrl", 160'(octrl), 160'(8'h00));
      check("rst_occupancy", 160'(occ), 160'(2'd0));
      check("rst_out_data", odata, 160'h0);
      check("rst_flushed_cnt", 160'(cnt), 160'(16'd0));
      rst_n = 1'b1;
      iv = 1'b0; ictrl = 8'h00;
      #1;
      check("rst_in_ready", 160'(irdy), 160'(1'b1));

      // Apply vector table, one row per clock
      for (int i = 0; i < 27; i++) begin
         iv = tbl[i].iv; ictrl = tbl[i].ictrl; idata = 160'(tbl[i].idata);
         ordy = tbl[i].ordy; fl = tbl[i].fl;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_out_valid", i), 160'(ov), 160'(tbl[i].ov));
         check($sformatf("v%0d_out_ctrl", i), 160'(octrl), 160'(tbl[i].octrl));
         check($sformatf("v%0d_out_data", i), odata, 160'(tbl[i].odata));
         check($sformatf("v%0d_occupancy", i), 160'(occ), 160'(tbl[i].occ));
         check($sformatf("v%0d_in_ready", i), 160'(irdy), 160'(tbl[i].irdy));
         check($sformatf("v%0d_flushed_cnt", i), 160'(cnt), 160'(tbl[i].cnt));
      end
      iv = 1'b0; ordy = 1'b0; fl = 1'b0;

      // Saturation: CNT_W=2, flush one entry four times
      for (int k = 1; k <= 4; k++) begin
         s_iv = 1'b1; s_ictrl = 8'h11; s_idata = 16'h1234; s_ordy = 1'b0; s_fl = 1'b0;
         @(posedge clk);
         #1;
         check($sformatf("sat%0d_loaded", k), 160'(s_ov), 160'(1'b1));
         s_iv = 1'b0; s_fl = 1'b1;
         @(posedge clk);
         #1;
         s_fl = 1'b0;
         check($sformatf("sat%0d_cnt", k), 160'(s_cnt), 160'((k > 3) ? 2'd3 : 2'(k)));
         check($sformatf("sat%0d_data_cleared", k), 160'(s_odata), 160'(16'h0000));
      end

      // SKID=0: out_ready toggling, in_ready combinational
      ov_m = 1'b0; data_m = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         z_iv = 1'b1; z_ictrl = 8'(8'h20 + i); z_idata = 16'(i + 1);
         z_ordy = (i % 2 == 1) ? 1'b1 : 1'b0;
         #1;
         rdy_m = ~ov_m | z_ordy;
         check($sformatf("s0_%0d_in_ready", i), 160'(z_irdy), 160'(rdy_m));
         if (rdy_m) begin
            ov_m = 1'b1; data_m = z_idata;
         end else if (ov_m && z_ordy) begin
            ov_m = 1'b0;
         end
         @(posedge clk);
         #1;
         check($sformatf("s0_%0d_out_valid", i), 160'(z_ov), 160'(ov_m));
         check($sformatf("s0_%0d_out_data", i), 160'(z_odata), 160'(data_m));
         check($sformatf("s0_%0d_occupancy", i), 160'(z_occ), 160'({1'b0, ov_m}));
      end
      z_iv = 1'b0; z_ordy = 1'b0;

      // Reset asserted mid-transfer drops the entry and clears the counter
      iv = 1'b1; ictrl = 8'h5A; idata = 160'h5A; ordy = 1'b0;
      @(posedge clk);
      #1;
      check("mid_loaded", 160'(ov), 160'(1'b1));
      iv = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 160'(ov), 160'(1'b0));
      check("mid_rst_out_ctrl", 160'(octrl), 160'(8'h00));
      check("mid_rst_occupancy", 160'(occ), 160'(2'd0));
      check("mid_rst_cnt", 160'(cnt), 160'(16'd0));
      check("mid_rst_out_data", odata, 160'h0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
